// File: rtl/framebuffer_reader.sv
// Streams a framebuffer out of RAM one pixel per request, prefetching words into a serializer + 2-deep FIFO.
// Latency: pixel is registered 1 clock after pix_req; a request with no pixel available raises a sticky underflow.
module framebuffer_reader #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int PIX_WIDTH   = 4,
   parameter int FRAME_WORDS = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  frame_start,
   input  logic                  pix_req,
   input  logic [DATA_WIDTH-1:0] read_data,
   output logic [ADDR_WIDTH-1:0] read_addr,
   output logic [PIX_WIDTH-1:0]  pixel,
   output logic                  pixel_valid,
   output logic                  underflow,
   output logic                  busy
);

   localparam int PPW    = DATA_WIDTH / PIX_WIDTH;
   localparam int IDX_W  = (PPW > 1) ? $clog2(PPW) : 1;
   localparam int FCNT_W = $clog2(FRAME_WORDS + 1);
   localparam int PCNT_W = $clog2(FRAME_WORDS * PPW + 1);
   localparam logic [FCNT_W-1:0] FRAME_WORDS_C = FCNT_W'(FRAME_WORDS);
   localparam logic [PCNT_W-1:0] TOTAL_PIX_C   = PCNT_W'(FRAME_WORDS * PPW);
   localparam logic [IDX_W-1:0]  LAST_IDX_C    = IDX_W'(PPW - 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] FILL   = 2'd1;
   localparam logic [1:0] STREAM = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] read_addr_q, read_addr_d;
   logic [FCNT_W-1:0]     fetch_cnt_q, fetch_cnt_d;
   logic [PCNT_W-1:0]     pix_cnt_q, pix_cnt_d;
   logic [DATA_WIDTH-1:0] ser_q, ser_d;
   logic                  ser_vld_q, ser_vld_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DATA_WIDTH-1:0] fifo_mem_q [2];
   logic [DATA_WIDTH-1:0] fifo_mem_d [2];
   logic                  fifo_rd_q, fifo_rd_d;
   logic                  fifo_wr_q, fifo_wr_d;
   logic [1:0]            fifo_cnt_q, fifo_cnt_d;
   logic [PIX_WIDTH-1:0]  pixel_q, pixel_d;
   logic                  pixel_valid_q, pixel_valid_d;
   logic                  underflow_q, underflow_d;

   logic running, consume, pop_word, fifo_pop, fetch, to_ser, fifo_push;

   always_comb begin
      running   = (state_q == FILL) || (state_q == STREAM);
      consume   = (state_q == STREAM) && pix_req && ser_vld_q;
      pop_word  = consume && (idx_q == LAST_IDX_C);
      fifo_pop  = pop_word && (fifo_cnt_q != 2'd0);
      fetch     = running && (fetch_cnt_q < FRAME_WORDS_C) &&
                  (!ser_vld_q || (fifo_cnt_q != 2'd2) || fifo_pop);
      // With an empty FIFO the fetched word bypasses straight into a draining serializer, keeping order.
      to_ser    = fetch && (!ser_vld_q || (pop_word && (fifo_cnt_q == 2'd0)));
      fifo_push = fetch && !to_ser;

      state_d       = state_q;
      read_addr_d   = read_addr_q;
      fetch_cnt_d   = fetch_cnt_q;
      pix_cnt_d     = pix_cnt_q;
      ser_d         = ser_q;
      ser_vld_d     = ser_vld_q;
      idx_d         = idx_q;
      fifo_mem_d    = fifo_mem_q;
      fifo_rd_d     = fifo_rd_q;
      fifo_wr_d     = fifo_wr_q;
      fifo_cnt_d    = fifo_cnt_q;
      pixel_d       = pixel_q;
      pixel_valid_d = 1'b0;
      underflow_d   = underflow_q;

      if (frame_start) begin
         state_d     = FILL;
         read_addr_d = '0;
         fetch_cnt_d = '0;
         pix_cnt_d   = '0;
         ser_vld_d   = 1'b0;
         idx_d       = '0;
         fifo_rd_d   = 1'b0;
         fifo_wr_d   = 1'b0;
         fifo_cnt_d  = 2'd0;
         underflow_d = 1'b0;
      end else begin
         if (consume) begin
            pixel_d       = ser_q[int'(idx_q)*PIX_WIDTH +: PIX_WIDTH];
            pixel_valid_d = 1'b1;
            pix_cnt_d     = pix_cnt_q + PCNT_W'(1);
            idx_d         = pop_word ? '0 : idx_q + IDX_W'(1);
         end else if (pix_req && running) begin
            underflow_d = 1'b1;
         end

         if (pop_word)
            ser_vld_d = 1'b0;
         if (fifo_pop) begin
            ser_d     = fifo_mem_q[fifo_rd_q];
            ser_vld_d = 1'b1;
            fifo_rd_d = ~fifo_rd_q;
         end
         if (to_ser) begin
            ser_d     = read_data;
            ser_vld_d = 1'b1;
         end
         if (fifo_push) begin
            fifo_mem_d[fifo_wr_q] = read_data;
            fifo_wr_d             = ~fifo_wr_q;
         end
         fifo_cnt_d = fifo_cnt_q + 2'(fifo_push) - 2'(fifo_pop);

         if (fetch) begin
            read_addr_d = read_addr_q + ADDR_WIDTH'(1);
            fetch_cnt_d = fetch_cnt_q + FCNT_W'(1);
         end

         if (state_q == FILL) begin
            if ((ser_vld_d && (fifo_cnt_d == 2'd2)) || (fetch_cnt_d == FRAME_WORDS_C))
               state_d = STREAM;
         end else if (state_q == STREAM) begin
            if (pix_cnt_d == TOTAL_PIX_C)
               state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         read_addr_q   <= '0;
         fetch_cnt_q   <= '0;
         pix_cnt_q     <= '0;
         ser_q         <= '0;
         ser_vld_q     <= 1'b0;
         idx_q         <= '0;
         fifo_mem_q[0] <= '0;
         fifo_mem_q[1] <= '0;
         fifo_rd_q     <= 1'b0;
         fifo_wr_q     <= 1'b0;
         fifo_cnt_q    <= 2'd0;
         pixel_q       <= '0;
         pixel_valid_q <= 1'b0;
         underflow_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         read_addr_q   <= read_addr_d;
         fetch_cnt_q   <= fetch_cnt_d;
         pix_cnt_q     <= pix_cnt_d;
         ser_q         <= ser_d;
         ser_vld_q     <= ser_vld_d;
         idx_q         <= idx_d;
         fifo_mem_q    <= fifo_mem_d;
         fifo_rd_q     <= fifo_rd_d;
         fifo_wr_q     <= fifo_wr_d;
         fifo_cnt_q    <= fifo_cnt_d;
         pixel_q       <= pixel_d;
         pixel_valid_q <= pixel_valid_d;
         underflow_q   <= underflow_d;
      end
   end

   assign read_addr   = read_addr_q;
   assign pixel       = pixel_q;
   assign pixel_valid = pixel_valid_q;
   assign underflow   = underflow_q;
   assign busy        = (state_q != IDLE);

endmodule
